// File: rtl/ddr2_user_arbiter.sv
// ddr2_user_arbiter: round-robin arbiter from one write and one read requester onto a MIG DDR2 user interface
// Ports: clk_in/reset (sync, active-high); phy_init_done gates leaving S_INIT;
//   wr_req/wr_addr/wr_data -> wr_ack; rd_req/rd_addr -> rd_ack;
//   app_af_afull/app_wdf_afull/rd_data_valid from MIG; app_af_*/app_wdf_* to MIG;
//   rd_pending counts outstanding read bursts; busy is high outside S_IDLE.
module ddr2_user_arbiter #(
    parameter int ADDR_W     = 31,
    parameter int MAX_RD_OUT = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              phy_init_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [127:0]      wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    input  logic              app_af_afull,
    input  logic              app_wdf_afull,
    input  logic              rd_data_valid,
    output logic              app_af_wren,
    output logic [2:0]        app_af_cmd,
    output logic [ADDR_W-1:0] app_af_addr,
    output logic              app_wdf_wren,
    output logic [63:0]       app_wdf_data,
    output logic [7:0]        app_wdf_mask_data,
    output logic [3:0]        rd_pending,
    output logic              busy
);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR1, S_WR2, S_RD} state_t;
    localparam logic [3:0] RD_MAX = 4'(MAX_RD_OUT);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              beat_q, beat_d;
    logic [3:0]        pend_q, pend_d;
    logic [63:0]       hi_q, hi_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              af_wren_q, af_wren_d;
    logic [2:0]        af_cmd_q, af_cmd_d;
    logic [ADDR_W-1:0] af_addr_q, af_addr_d;
    logic              wdf_wren_q, wdf_wren_d;
    logic [63:0]       wdf_data_q, wdf_data_d;
    logic              busy_q, busy_d;
    logic              wr_ok, rd_ok, gnt_wr, gnt_rd, beat_in, dec;

    always_comb begin
        wr_ok      = wr_req & ~app_af_afull & ~app_wdf_afull;
        rd_ok      = rd_req & ~app_af_afull & (pend_q < RD_MAX);
        // last_q=1 means read was granted last, so write wins a tie
        gnt_wr     = (state_q == S_IDLE) & wr_ok & (~rd_ok | last_q);
        gnt_rd     = (state_q == S_IDLE) & rd_ok & ~gnt_wr;
        last_d     = gnt_wr ? 1'b0 : gnt_rd ? 1'b1 : last_q;
        hi_d       = gnt_wr ? wr_data[127:64] : hi_q;
        af_wren_d  = gnt_wr | gnt_rd;
        af_cmd_d   = {2'b00, gnt_rd};
        af_addr_d  = gnt_wr ? wr_addr : gnt_rd ? rd_addr : af_addr_q;
        wdf_wren_d = gnt_wr | (state_q == S_WR1);
        wdf_data_d = gnt_wr ? wr_data[63:0] : (state_q == S_WR1) ? hi_q : wdf_data_q;
        wr_ack_d   = gnt_wr;
        rd_ack_d   = gnt_rd;
        // beats arriving with nothing outstanding are stray and must not disturb pairing
        beat_in    = rd_data_valid & (pend_q != 4'd0);
        dec        = beat_in & beat_q;
        beat_d     = beat_in ? ~beat_q : beat_q;
        pend_d     = pend_q + {3'b000, gnt_rd} - {3'b000, dec};
        state_d    = state_q;
        case (state_q)
            S_INIT:  state_d = phy_init_done ? S_IDLE : S_INIT;
            S_IDLE:  state_d = gnt_wr ? S_WR1 : gnt_rd ? S_RD : S_IDLE;
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = S_IDLE;
            S_RD:    state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= S_INIT;
            last_q     <= 1'b1;
            beat_q     <= 1'b0;
            pend_q     <= 4'd0;
            hi_q       <= 64'd0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            af_wren_q  <= 1'b0;
            af_cmd_q   <= 3'd0;
            af_addr_q  <= '0;
            wdf_wren_q <= 1'b0;
            wdf_data_q <= 64'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
            pend_q     <= pend_d;
            hi_q       <= hi_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            af_wren_q  <= af_wren_d;
            af_cmd_q   <= af_cmd_d;
            af_addr_q  <= af_addr_d;
            wdf_wren_q <= wdf_wren_d;
            wdf_data_q <= wdf_data_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_ack            = wr_ack_q;
    assign rd_ack            = rd_ack_q;
    assign app_af_wren       = af_wren_q;
    assign app_af_cmd        = af_cmd_q;
    assign app_af_addr       = af_addr_q;
    assign app_wdf_wren      = wdf_wren_q;
    assign app_wdf_data      = wdf_data_q;
    assign app_wdf_mask_data = 8'd0;
    assign rd_pending        = pend_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_ddr2_user_arbiter.sv
// tb_ddr2_user_arbiter: scoreboard bench for ddr2_user_arbiter
module tb_ddr2_user_arbiter;
    localparam int AW = 31;
    logic          clk_in = 1'b0;
    logic          reset, phy_init_done, wr_req, rd_req;
    logic          app_af_afull, app_wdf_afull, rd_data_valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [127:0]  wr_data;
    logic          wr_ack, rd_ack, app_af_wren, app_wdf_wren, busy;
    logic [2:0]    app_af_cmd;
    logic [AW-1:0] app_af_addr;
    logic [63:0]   app_wdf_data;
    logic [7:0]    app_wdf_mask_data;
    logic [3:0]    rd_pending;

    ddr2_user_arbiter #(.ADDR_W(AW), .MAX_RD_OUT(8)) dut (
        .clk_in(clk_in), .reset(reset), .phy_init_done(phy_init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull), .rd_data_valid(rd_data_valid),
        .app_af_wren(app_af_wren), .app_af_cmd(app_af_cmd), .app_af_addr(app_af_addr),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_mask_data(app_wdf_mask_data),
        .rd_pending(rd_pending), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    int          errs = 0, checks = 0, wr_acks = 0, rd_acks = 0;
    logic [63:0] exp_cmd[$];
    logic [63:0] exp_wd[$];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    function automatic logic [63:0] mk(input logic [2:0] c, input logic [AW-1:0] a);
        return {30'd0, c, a};
    endfunction

    // monitor: every strobe the DUT presents is matched against the scoreboard
    always @(negedge clk_in) begin
        if (app_af_wren === 1'b1) begin
            if (exp_cmd.size() == 0) begin
                checks++; errs++;
                $display("FAIL unexpected_cmd: got %h expected none", mk(app_af_cmd, app_af_addr));
            end else chk("cmd", mk(app_af_cmd, app_af_addr), exp_cmd.pop_front());
            chk("mask", {56'd0, app_wdf_mask_data}, 64'd0);
        end
        if (app_wdf_wren === 1'b1) begin
            if (exp_wd.size() == 0) begin
                checks++; errs++;
                $display("FAIL unexpected_wdf: got %h expected none", app_wdf_data);
            end else chk("wdf_data", app_wdf_data, exp_wd.pop_front());
        end
        if (wr_ack === 1'b1) wr_acks++;
        if (rd_ack === 1'b1) rd_acks++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_wr_ack(input string n);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr_ack) return;
        end
        checks++; errs++;
        $display("FAIL %s: got no wr_ack expected wr_ack within 40 cycles", n);
    endtask

    task automatic wait_rd_ack(input string n);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rd_ack) return;
        end
        checks++; errs++;
        $display("FAIL %s: got no rd_ack expected rd_ack within 40 cycles", n);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        exp_cmd.push_back(mk(3'b001, a));
        rd_addr = a;
        rd_req  = 1'b1;
        wait_rd_ack("do_read");
        rd_req = 1'b0;
    endtask

    task automatic beats(input int n);
        rd_data_valid = 1'b1;
        repeat (n) tick();
        rd_data_valid = 1'b0;
    endtask

    task automatic wr_agent();
        for (int i = 0; i < 4; i++) begin
            wr_addr = AW'(32'h200 + 32'(i) * 4);
            wr_data = {32'hA0A0_0000 + 32'(i), 32'hA1A1_0000 + 32'(i), 32'hB0B0_0000 + 32'(i), 32'hB1B1_0000 + 32'(i)};
            wr_req  = 1'b1;
            wait_wr_ack("rr_wr");
        end
        wr_req = 1'b0;
    endtask

    task automatic rd_agent();
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(32'h280 + 32'(i) * 4);
            rd_req  = 1'b1;
            wait_rd_ack("rr_rd");
        end
        rd_req = 1'b0;
    endtask

    initial begin
        int snap_w, snap_r;
        reset = 1'b1; phy_init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        app_af_afull = 1'b0; app_wdf_afull = 1'b0; rd_data_valid = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        repeat (3) tick();
        chk("rst_strobes", {app_af_wren, app_wdf_wren, wr_ack, rd_ack, busy}, 64'd0);
        chk("rst_cmd_addr", mk(app_af_cmd, app_af_addr), 64'd0);
        chk("rst_wdf_data", app_wdf_data, 64'd0);
        chk("rst_pending", rd_pending, 64'd0);

        // init gating
        reset   = 1'b0;
        wr_addr = AW'(32'h40);
        wr_data = 128'hCCCC_CCCC_CCCC_CCCC_DDDD_DDDD_DDDD_DDDD;
        wr_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("init_no_cmd", app_af_wren, 64'd0);
        end
        chk("init_busy", busy, 64'd1);
        exp_cmd.push_back(mk(3'b000, AW'(32'h40)));
        exp_wd.push_back(64'hDDDD_DDDD_DDDD_DDDD);
        exp_wd.push_back(64'hCCCC_CCCC_CCCC_CCCC);
        phy_init_done = 1'b1;
        tick();
        chk("init_idle_busy", busy, 64'd0);
        chk("init_idle_noack", wr_ack, 64'd0);
        tick();
        chk("init_grant_ack", wr_ack, 64'd1);
        wr_req = 1'b0;
        tick();
        tick();
        chk("init_back_idle", busy, 64'd0);

        // single write, explicit cycle-by-cycle
        exp_cmd.push_back(mk(3'b000, AW'(32'h100)));
        exp_wd.push_back(64'h2222_2222_2222_2222);
        exp_wd.push_back(64'h1111_1111_1111_1111);
        wr_addr = AW'(32'h100);
        wr_data = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
        wr_req  = 1'b1;
        tick();
        chk("w1_strobes", {app_af_wren, app_wdf_wren, wr_ack}, 64'h7);
        chk("w1_cmd_addr", mk(app_af_cmd, app_af_addr), mk(3'b000, AW'(32'h100)));
        chk("w1_data", app_wdf_data, 64'h2222_2222_2222_2222);
        wr_req = 1'b0;
        tick();
        chk("w2_strobes", {app_af_wren, app_wdf_wren, wr_ack}, 64'h2);
        chk("w2_data", app_wdf_data, 64'h1111_1111_1111_1111);
        tick();
        chk("w3_idle", {busy, app_wdf_wren, app_af_wren}, 64'd0);

        // fresh reset, then both ports requesting continuously: W,R,W,R...
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_cmd.push_back(mk(3'b000, AW'(32'h200 + 32'(i) * 4)));
            exp_cmd.push_back(mk(3'b001, AW'(32'h280 + 32'(i) * 4)));
            exp_wd.push_back({32'hB0B0_0000 + 32'(i), 32'hB1B1_0000 + 32'(i)});
            exp_wd.push_back({32'hA0A0_0000 + 32'(i), 32'hA1A1_0000 + 32'(i)});
        end
        fork
            wr_agent();
            rd_agent();
        join
        tick();
        chk("rr_pending", rd_pending, 64'd4);

        // drain, then a stray beat with nothing outstanding
        beats(8);
        chk("drain_pending", rd_pending, 64'd0);
        beats(1);
        chk("stray_beat", rd_pending, 64'd0);

        // outstanding-read limit
        for (int i = 0; i < 8; i++) do_read(AW'(32'h300 + 32'(i) * 4));
        tick();
        chk("limit_pending8", rd_pending, 64'd8);
        exp_cmd.push_back(mk(3'b001, AW'(32'h3F0)));
        rd_addr = AW'(32'h3F0);
        rd_req  = 1'b1;
        snap_r  = rd_acks;
        repeat (10) tick();
        chk("ninth_blocked", 64'(rd_acks - snap_r), 64'd0);
        beats(1);
        chk("one_beat_pending", rd_pending, 64'd8);
        beats(1);
        chk("two_beat_pending", rd_pending, 64'd7);
        wait_rd_ack("ninth_grant");
        chk("ninth_pending", rd_pending, 64'd8);
        rd_req = 1'b0;

        // simultaneous increment and decrement
        beats(2);
        beats(1);
        chk("sim_pre_pending", rd_pending, 64'd7);
        exp_cmd.push_back(mk(3'b001, AW'(32'h3F4)));
        rd_addr       = AW'(32'h3F4);
        rd_req        = 1'b1;
        rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
        rd_req        = 1'b0;
        chk("sim_ack", rd_ack, 64'd1);
        chk("sim_pending", rd_pending, 64'd7);
        beats(14);
        chk("drain2_pending", rd_pending, 64'd0);

        // almost-full blocking
        app_af_afull = 1'b1;
        wr_addr = AW'(32'h500);
        rd_addr = AW'(32'h580);
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        snap_w  = wr_acks;
        snap_r  = rd_acks;
        repeat (10) tick();
        chk("af_afull_no_grant", 64'((wr_acks - snap_w) + (rd_acks - snap_r)), 64'd0);
        wr_req = 1'b0;
        rd_req = 1'b0;
        app_af_afull  = 1'b0;
        app_wdf_afull = 1'b1;
        tick();
        wr_req = 1'b1;
        snap_w = wr_acks;
        do_read(AW'(32'h584));
        do_read(AW'(32'h588));
        tick();
        chk("wdf_afull_no_wr", 64'(wr_acks - snap_w), 64'd0);
        chk("wdf_afull_pending", rd_pending, 64'd2);
        wr_req = 1'b0;
        tick();
        app_wdf_afull = 1'b0;

        // reset asserted in S_WR1
        exp_cmd.push_back(mk(3'b000, AW'(32'h600)));
        exp_wd.push_back(64'h5555_5555_5555_5555);
        wr_addr = AW'(32'h600);
        wr_data = 128'h4444_4444_4444_4444_5555_5555_5555_5555;
        wr_req  = 1'b1;
        wait_wr_ack("abort_grant");
        reset = 1'b1;
        wr_req = 1'b0;
        phy_init_done = 1'b0;
        tick();
        chk("abort_strobes", {app_af_wren, app_wdf_wren, wr_ack, rd_ack, busy}, 64'd0);
        chk("abort_pending", rd_pending, 64'd0);
        reset = 1'b0;
        tick();
        chk("abort_init_busy", busy, 64'd1);
        chk("abort_no_beat1", app_wdf_wren, 64'd0);
        beats(2);
        chk("abort_stray_pending", rd_pending, 64'd0);
        phy_init_done = 1'b1;
        repeat (2) tick();

        chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
        chk("wdf_queue_empty", 64'(exp_wd.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ddr2_user_arbiter.md
DDR2_USER_ARBITER -- requirements
Module: ddr2_user_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 31, MIG app address width; MAX_RD_OUT, default 8, maximum outstanding read commands.
REQ-002 clk_in  in  1  single clock for all logic, the MIG user-interface clock.
REQ-003 reset  in  1  synchronous reset, active-high.
REQ-004 phy_init_done  in  1  MIG calibration complete.
REQ-005 wr_req  in  1  write request, held until wr_ack.
REQ-006 wr_addr  in  ADDR_W  write burst address.
REQ-007 wr_data  in  128  burst data; [63:0] is beat 0 and [127:64] is beat 1.
REQ-008 wr_ack  out  1  one-cycle write grant pulse.
REQ-009 rd_req  in  1  read request, held until rd_ack.
REQ-010 rd_addr  in  ADDR_W  read burst address.
REQ-011 rd_ack  out  1  one-cycle read grant pulse.
REQ-012 app_af_afull  in  1  MIG address FIFO almost full.
REQ-013 app_wdf_afull  in  1  MIG write-data FIFO almost full.
REQ-014 rd_data_valid  in  1  MIG read-data beat valid; two beats per burst.
REQ-015 app_af_wren  out  1  address/command FIFO write strobe.
REQ-016 app_af_cmd  out  3  command: 000 is write, 001 is read.
REQ-017 app_af_addr  out  ADDR_W  command address.
REQ-018 app_wdf_wren  out  1  write-data FIFO write strobe.
REQ-019 app_wdf_data  out  64  write-data beat.
REQ-020 app_wdf_mask_data  out  8  byte mask; always 0.
REQ-021 rd_pending  out  4  outstanding read bursts.
REQ-022 busy  out  1  high in every state except S_IDLE.

Function
REQ-023 All outputs SHALL be registered.
REQ-024 The FSM states SHALL be S_INIT, S_IDLE, S_WR1, S_WR2 and S_RD.
REQ-025 S_INIT SHALL hold until phy_init_done=1, then move to S_IDLE; phy_init_done SHALL be ignored in every other state.
REQ-026 In S_IDLE, the write port is eligible when wr_req & !app_af_afull & !app_wdf_afull.
REQ-027 In S_IDLE, the read port is eligible when rd_req & !app_af_afull & (rd_pending < MAX_RD_OUT).
REQ-028 When both ports are eligible, grant SHALL alternate round-robin using a last_grant flag; the port not granted last wins.
REQ-029 When only one port is eligible, that port SHALL be granted; when none is eligible, the FSM stays in S_IDLE and all strobes are 0.
REQ-030 Write grant sampled in cycle N: in cycle N+1 (S_WR1), app_af_wren=1, cmd=000, app_af_addr=wr_addr, app_wdf_wren=1, app_wdf_data=wr_data[63:0] and wr_ack=1.
REQ-031 In cycle N+2 (S_WR2), app_wdf_wren=1, app_wdf_data=wr_data[127:64] and app_af_wren=0; the FSM returns to S_IDLE at N+3.
REQ-032 Read grant sampled in cycle N: in cycle N+1 (S_RD), app_af_wren=1, cmd=001, app_af_addr=rd_addr and rd_ack=1; the FSM returns to S_IDLE at N+2.
REQ-033 Address and data SHALL be captured at grant; later requester changes do not affect the burst in flight.
REQ-034 Almost-full inputs SHALL be evaluated only in S_IDLE; once granted, a burst always completes, since the MIG FIFOs tolerate this slack.
REQ-035 rd_pending SHALL increment on each read command issue and decrement on every second rd_data_valid beat, tracked by a beat-toggle bit.
REQ-036 A simultaneous increment and decrement of rd_pending SHALL leave it unchanged.
REQ-037 When rd_pending=0, rd_data_valid SHALL be ignored: no underflow and no toggle change.
REQ-038 rd_pending SHALL never exceed MAX_RD_OUT.
REQ-039 last_grant SHALL update only when a grant is issued.

Reset
REQ-040 On reset: state=S_INIT; every output 0; rd_pending=0; beat toggle=0; last_grant=read, so write wins the first tie.
REQ-041 Reset asserted mid-burst (S_WR1, S_WR2 or S_RD) SHALL abort the burst immediately, with no further strobes; reset has priority over every event.

Verification
REQ-042 Init gating: wr_req=1 held while phy_init_done=0 for 20 cycles -> no app_af_wren and busy=1; phy_init_done rises -> S_IDLE next cycle, and the write is granted the following cycle.
REQ-043 Single write, addr=0x100, data=128'h1111..._2222...: -> N+1: af_wren, cmd=000, addr=0x100, wdf_data=beat0 and wr_ack; N+2: wdf_data=beat1; N+3: idle.
REQ-044 Both ports requesting continuously -> command order W,R,W,R...; after reset, the first grant is write.
REQ-045 Issue 8 reads with no rd_data_valid -> rd_pending=8, and a ninth rd_req stays unacked; supply 2 rd_data_valid beats -> rd_pending=7, and the ninth read is granted.
REQ-046 app_af_afull=1 with both ports requesting -> no grant for 10 cycles; app_wdf_afull=1 only -> reads granted and writes blocked.
REQ-047 Reset asserted in S_WR1 -> next cycle all outputs 0 and state S_INIT; rd_data_valid arriving with rd_pending=0 -> rd_pending stays 0.
